mprj_io_cfg_sequencer: RTL

Serial configuration sequencer for the user-project I/O pad ring. It reads one configuration word per `mprj_io` pad from a register file and shifts all words down the daisy-chained pad control blocks. It then pulses the chain load strobe so every pad's mode (`dm`, `oeb`, `inp_dis`, `ib_mode_sel`, `vtrip_sel`, `slow_sel`, `holdover`, analog controls) updates at once. The block sits in the management core between the housekeeping register file and the pad control chain feeding the padframe.

---
 rtl/mprj_io_cfg_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mprj_io_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// mprj_io_cfg_sequencer
//
// Walks the housekeeping register file from the highest pad index down to 0.
// Each configuration word is shifted MSB first into the daisy-chained pad
// control blocks. After the last bit, the chain load strobe is pulsed so every
// pad picks up its new mode at the same time.
//
// Parameters
//   NUM_PADS  pads in the chain (>= 1)
//   CFG_BITS  bits per pad configuration word (>= 1)
//   CLK_DIV   clock cycles per serial-clock phase, low and high (>= 1)
//
// Ports
//   clock, reset      block clock; asynchronous active-high reset
//   start             request a full chain transfer (sampled in IDLE only)
//   abort             cancel the transfer in progress (ignored in IDLE)
//   busy              transfer in progress
//   done / aborted    one-cycle completion / cancellation pulses
//   cfg_rd_idx        pad index presented to the register file
//   cfg_rd_data       combinational register-file read data for cfg_rd_idx
//   serial_clock      chain shift clock (chain samples on its rising edge)
//   serial_data       chain data
//   serial_load       chain latch strobe
//   serial_resetn     chain reset, active-low
//
// Request handshake: start is a level request that is taken only in a cycle
// where busy is low. Once taken, busy is high from the next cycle until the
// cycle in which done or aborted pulses. That same cycle may already take
// the next start. A start seen while busy is high is dropped, not queued.
//
// Every output is a flop. The next-state block works out each output's value
// for the coming cycle together with the state transition.
// ---------------------------------------------------------------------------
module mprj_io_cfg_sequencer #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 1,
    localparam int IDX_W   = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [IDX_W-1:0]    cfg_rd_idx,
    input  logic [CFG_BITS-1:0] cfg_rd_data,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                serial_resetn
);

    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_PAD  = IDX_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CFG_BITS - 1);
    localparam logic [PH_W-1:0]  PH_RELOAD = PH_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CFG_BITS-1:0] sreg;
    logic [CFG_BITS-1:0] sreg_nx;
    logic [BIT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    bit_cnt_nx;
    logic [PH_W-1:0]     ph_cnt;
    logic [PH_W-1:0]     ph_cnt_nx;
    logic [IDX_W-1:0]    idx_nx;
    logic                phase_end;
    logic                busy_nx;
    logic                done_nx;
    logic                aborted_nx;
    logic                sclk_nx;
    logic                sdata_nx;
    logic                sload_nx;
    logic                sresetn_nx;

    assign phase_end = (ph_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            sreg          <= '0;
            bit_cnt       <= '0;
            ph_cnt        <= '0;
            cfg_rd_idx    <= LAST_PAD;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            serial_clock  <= 1'b0;
            serial_data   <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b0;
        end else begin
            state         <= state_nx;
            sreg          <= sreg_nx;
            bit_cnt       <= bit_cnt_nx;
            ph_cnt        <= ph_cnt_nx;
            cfg_rd_idx    <= idx_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            aborted       <= aborted_nx;
            serial_clock  <= sclk_nx;
            serial_data   <= sdata_nx;
            serial_load   <= sload_nx;
            serial_resetn <= sresetn_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sreg_nx    = sreg;
        bit_cnt_nx = bit_cnt;
        idx_nx     = cfg_rd_idx;
        done_nx    = 1'b0;
        aborted_nx = 1'b0;
        sresetn_nx = 1'b1;
        sdata_nx   = serial_data;

        if (abort && (state != S_IDLE)) begin
            // Return to IDLE with a quiet bus. A one-cycle chain reset
            // flushes the partially shifted words.
            state_nx   = S_IDLE;
            aborted_nx = 1'b1;
            sresetn_nx = 1'b0;
            sdata_nx   = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx = S_LOAD;
                        idx_nx   = LAST_PAD;
                    end
                end
                S_LOAD: begin
                    sreg_nx    = cfg_rd_data;
                    bit_cnt_nx = LAST_BIT;
                    sdata_nx   = cfg_rd_data[CFG_BITS-1];
                    state_nx   = S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    if (phase_end) begin
                        state_nx = S_SHIFT_HI;
                    end
                end
                S_SHIFT_HI: begin
                    if (phase_end) begin
                        if (bit_cnt != '0) begin
                            sreg_nx    = sreg << 1;
                            bit_cnt_nx = bit_cnt - BIT_W'(1);
                            // The new bit goes out together with the falling
                            // edge of serial_clock. It then stays stable for
                            // the whole low phase.
                            sdata_nx   = sreg_nx[CFG_BITS-1];
                            state_nx   = S_SHIFT_LO;
                        end else if (cfg_rd_idx != '0) begin
                            idx_nx   = cfg_rd_idx - IDX_W'(1);
                            state_nx = S_LOAD;
                        end else begin
                            state_nx = S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    if (phase_end) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end

        // One phase counter serves every timed state. It restarts on each
        // state change. SHIFT and LATCH always leave at phase end, so each
        // of them lasts exactly CLK_DIV cycles.
        if (state_nx != state) begin
            ph_cnt_nx = PH_RELOAD;
        end else if (!phase_end) begin
            ph_cnt_nx = ph_cnt - PH_W'(1);
        end else begin
            ph_cnt_nx = ph_cnt;
        end

        busy_nx  = (state_nx != S_IDLE);
        sclk_nx  = (state_nx == S_SHIFT_HI);
        sload_nx = (state_nx == S_LATCH);
    end

endmodule
